// File: rtl/rc4_ksa_if.sv
// RC4 key-scheduling engine bus: controller handshake, key, and single-port S-RAM.
interface rc4_ksa_if;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [7:0]  addr;
  logic [7:0]  rddata;
  logic [7:0]  wrdata;
  logic        wren;

  modport slave  (input en, key, rddata, output rdy, addr, wrdata, wren);
  modport master (output en, key, rddata, input rdy, addr, wrdata, wren);
endinterface

// File: rtl/rc4_ksa.sv
// RC4 KSA: swaps S[i] and S[j] for i=0..255 over an external synchronous RAM,
// six cycles per i, with all outputs registered off the next-state values.
module rc4_ksa (
  input logic        clk,
  input logic        rst_n,
  rc4_ksa_if.slave   bus
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_READ_I  = 3'd1;
  localparam logic [2:0] S_WAIT_I  = 3'd2;
  localparam logic [2:0] S_READ_J  = 3'd3;
  localparam logic [2:0] S_WAIT_J  = 3'd4;
  localparam logic [2:0] S_WRITE_I = 3'd5;
  localparam logic [2:0] S_WRITE_J = 3'd6;

  logic [2:0] state_q, state_d;
  logic [7:0] i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
  logic [7:0] addr_q, addr_d, wrdata_q, wrdata_d;
  logic       wren_q, wren_d, rdy_q, rdy_d;
  logic [7:0] kb;

  // Key is read live; the byte is picked by i mod 3 on the 8-bit index.
  always_comb begin
    case (i_q % 8'd3)
      8'd0:    kb = bus.key[23:16];
      8'd1:    kb = bus.key[15:8];
      default: kb = bus.key[7:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    si_d    = si_q;
    sj_d    = sj_q;
    case (state_q)
      S_IDLE: if (bus.en) begin
        i_d     = 8'd0;
        j_d     = 8'd0;
        state_d = S_READ_I;
      end
      S_READ_I: state_d = S_WAIT_I;
      S_WAIT_I: begin
        si_d    = bus.rddata;
        j_d     = j_q + bus.rddata + kb;
        state_d = S_READ_J;
      end
      S_READ_J: state_d = S_WAIT_J;
      S_WAIT_J: begin
        sj_d    = bus.rddata;
        state_d = S_WRITE_I;
      end
      S_WRITE_I: state_d = S_WRITE_J;
      S_WRITE_J: begin
        if (i_q == 8'd255) state_d = S_IDLE;
        else begin
          i_d     = i_q + 8'd1;
          state_d = S_READ_I;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output registers are loaded from the state being entered, so the RAM
  // sees address/data during the state itself with no input-to-output path.
  always_comb begin
    addr_d   = 8'd0;
    wrdata_d = 8'd0;
    wren_d   = 1'b0;
    rdy_d    = (state_d == S_IDLE);
    case (state_d)
      S_READ_I:  addr_d = i_d;
      S_READ_J:  addr_d = j_d;
      S_WRITE_I: begin addr_d = i_d; wrdata_d = sj_d; wren_d = 1'b1; end
      S_WRITE_J: begin addr_d = j_d; wrdata_d = si_d; wren_d = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      i_q      <= 8'd0;
      j_q      <= 8'd0;
      si_q     <= 8'd0;
      sj_q     <= 8'd0;
      addr_q   <= 8'd0;
      wrdata_q <= 8'd0;
      wren_q   <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      si_q     <= si_d;
      sj_q     <= sj_d;
      addr_q   <= addr_d;
      wrdata_q <= wrdata_d;
      wren_q   <= wren_d;
      rdy_q    <= rdy_d;
    end
  end

  assign bus.addr   = addr_q;
  assign bus.wrdata = wrdata_q;
  assign bus.wren   = wren_q;
  assign bus.rdy    = rdy_q;
endmodule

// File: tb/tb_rc4_ksa.sv
// Bench for rc4_ksa: synchronous RAM model, software KSA scoreboard of writes,
// per-key vector table, and hand-checked first-iteration / mid-run reset sequences.
module tb_rc4_ksa;
  logic clk, rst_n, ram_init;
  rc4_ksa_if bus();
  rc4_ksa dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [7:0] mem [256];
  int checks = 0, failures = 0;

  typedef struct { logic [7:0] a; logic [7:0] d; } wr_t;
  wr_t exp_q[$];
  logic [7:0] model_s [256];

  typedef struct { logic [23:0] key; logic [7:0] rj0; logic [7:0] rj1; } vec_t;
  vec_t vecs [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (ram_init) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (bus.wren) begin
      mem[bus.addr] <= bus.wrdata;
    end
    bus.rddata <= mem[bus.addr];
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_push(input logic [23:0] key);
    logic [7:0] j, t, kb;
    exp_q.delete();
    for (int k = 0; k < 256; k++) model_s[k] = 8'(k);
    j = 8'd0;
    for (int i = 0; i < 256; i++) begin
      kb = (i % 3 == 0) ? key[23:16] : (i % 3 == 1) ? key[15:8] : key[7:0];
      j = j + model_s[i] + kb;
      exp_q.push_back('{a: 8'(i), d: model_s[j]});
      exp_q.push_back('{a: j, d: model_s[i]});
      t = model_s[i]; model_s[i] = model_s[j]; model_s[j] = t;
    end
  endtask

  task automatic init_ram();
    @(negedge clk); ram_init = 1'b1;
    @(negedge clk); ram_init = 1'b0;
  endtask

  // Runs one full schedule; cycle c=0 is READ_I of i=0.
  task automatic run_key(input vec_t v, input bit trace);
    int c, bad, first_bad;
    wr_t w;
    logic [7:0] tr_a [12];
    logic       tr_w [12];
    logic [7:0] tr_d [12];
    tr_a = '{0,0,0,0,0,0,1,0,4,0,1,4};
    tr_w = '{0,0,0,0,1,1,0,0,0,0,1,1};
    tr_d = '{0,0,0,0,0,0,0,0,0,0,4,1};
    init_ram();
    bus.key = v.key;
    model_push(v.key);
    bus.en = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    c = 0; bad = 0; first_bad = 1;
    while (bus.rdy == 1'b0 && c < 3000) begin
      if (trace && c < 12) begin
        chk($sformatf("trace_addr_c%0d", c), bus.addr, tr_a[c]);
        chk($sformatf("trace_wren_c%0d", c), bus.wren, tr_w[c]);
        chk($sformatf("trace_wrdata_c%0d", c), bus.wrdata, tr_d[c]);
      end
      if (c == 2) chk("read_j_i0", bus.addr, v.rj0);
      if (c == 8) chk("read_j_i1", bus.addr, v.rj1);
      if (c % 6 == 0 && bus.addr != 8'(c / 6)) bad++;
      if (bus.wren) begin
        if (exp_q.size() == 0) bad++;
        else begin
          w = exp_q.pop_front();
          if (w.a != bus.addr || w.d != bus.wrdata) begin
            bad++;
            if (first_bad) $display("FAIL write c=%0d actual a=%0d d=%0d expected a=%0d d=%0d",
                                    c, bus.addr, bus.wrdata, w.a, w.d);
            first_bad = 0;
          end
        end
      end
      if (c == 50) bus.en = 1'b1;
      if (c == 51) bus.en = 1'b0;
      @(negedge clk);
      c++;
    end
    chk("run_cycles", c, 1536);
    chk("write_mismatches", bad, 0);
    chk("writes_left", exp_q.size(), 0);
    @(negedge clk);
    bad = 0;
    for (int k = 0; k < 256; k++) if (mem[k] != model_s[k]) bad++;
    chk("final_ram", bad, 0);
    chk("idle_rdy", bus.rdy, 1);
  endtask

  initial begin
    vecs[0] = '{key: 24'h00033C, rj0: 8'h00, rj1: 8'h04};
    vecs[1] = '{key: 24'hFFFFFF, rj0: 8'hFF, rj1: 8'hFF};
    vecs[2] = '{key: 24'h010203, rj0: 8'h01, rj1: 8'h03};
    vecs[3] = '{key: 24'h123456, rj0: 8'h12, rj1: 8'h47};
    ram_init = 1'b0;
    bus.en = 1'b1;
    bus.key = 24'h00033C;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_rdy", bus.rdy, 1);
    chk("rst_addr", bus.addr, 0);
    chk("rst_wrdata", bus.wrdata, 0);
    chk("rst_wren", bus.wren, 0);
    bus.en = 1'b0;
    @(negedge clk);
    chk("idle_hold_rdy", bus.rdy, 1);

    run_key(vecs[0], 1'b1);
    for (int n = 1; n < 4; n++) run_key(vecs[n], 1'b0);

    // Abort in WRITE_I of i=10, then restart cleanly.
    init_ram();
    bus.key = 24'h00033C;
    bus.en = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    repeat (10 * 6 + 4) @(negedge clk);
    chk("pre_abort_wren", bus.wren, 1);
    chk("pre_abort_addr", bus.addr, 10);
    rst_n = 1'b0;
    #1;
    chk("abort_rdy", bus.rdy, 1);
    chk("abort_wren", bus.wren, 0);
    chk("abort_addr", bus.addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_key(vecs[0], 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
